// File: rtl/fetch_branch_unit_if.sv
// Instruction memory handshake bundle between the fetch/branch unit and imem.
// The fetch unit is the master: it drives addr/req, memory returns ack/data.
interface fetch_branch_unit_if;
    logic [7:0] addr;
    logic       req;
    logic       ack;
    logic [7:0] data;

    modport master (
        output addr,
        output req,
        input  ack,
        input  data
    );

    modport slave (
        input  addr,
        input  req,
        output ack,
        output data
    );
endinterface

// File: rtl/fetch_branch_unit.sv
// Fetch/branch sequencer beside the 8-bit PC: fetches the word at pc over the
// imem req/ack handshake, then spends one cycle decoding it and telling the PC
// how to move.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | one cycle after reset release, nothing requested yet
// S_FETCH   | imem_req high at addr=pc, waiting up to TIMEOUT+1 cycles
// S_EXECUTE | captured word is valid; pc_advance/pc_control/jump_offset
// S_HALTED  | HALT executed; parked until reset
// S_FAULT   | fetch timed out; parked until reset
module fetch_branch_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 i_pc,
    input  logic                       i_zero_flag,
    fetch_branch_unit_if.master        imem,
    output logic [7:0]                 o_pc_control,
    output logic [7:0]                 o_jump_offset,
    output logic                       o_pc_advance,
    output logic [7:0]                 o_instr,
    output logic                       o_instr_valid,
    output logic                       o_halted,
    output logic                       o_fault
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_EXECUTE = 3'd2,
        S_HALTED  = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    localparam logic [2:0] OP_JMP  = 3'b111;
    localparam logic [2:0] OP_BEQZ = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b101;

    // Terminal count of the fetch wait counter; counter value equals the
    // number of un-acked FETCH cycles already spent.
    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_instr;
    logic [7:0] r_wait_cnt;

    logic [2:0] w_opcode;
    logic       w_taken;
    logic       w_req;
    logic [7:0] w_addr;
    logic       w_advance;
    logic       w_valid;
    logic       w_halted;
    logic       w_fault;

    assign w_opcode = r_instr[7:5];

    // State register; reset aborts any fetch or execute in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the instruction on ack and count un-acked fetch cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= 8'h00;
            r_wait_cnt <= 8'h00;
        end else if (r_state == S_FETCH) begin
            if (imem.ack) begin
                r_instr    <= imem.data;
                r_wait_cnt <= 8'h00;
            end else begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    // Next-state and output decode from registered state/instr; an ack in the
    // cycle the counter hits terminal count still wins over the timeout.
    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_addr       = 8'h00;
        w_advance    = 1'b0;
        w_valid      = 1'b0;
        w_taken      = 1'b0;
        w_halted     = 1'b0;
        w_fault      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                w_req  = 1'b1;
                w_addr = i_pc;
                if (imem.ack) begin
                    w_next_state = S_EXECUTE;
                end else if (r_wait_cnt == LP_TIMEOUT) begin
                    w_next_state = S_FAULT;
                end
            end
            S_EXECUTE: begin
                w_valid      = 1'b1;
                w_advance    = 1'b1;
                w_next_state = S_FETCH;
                case (w_opcode)
                    OP_JMP:  w_taken = 1'b1;
                    OP_BEQZ: w_taken = i_zero_flag;
                    OP_HALT: begin
                        w_advance    = 1'b0;
                        w_next_state = S_HALTED;
                    end
                    default: w_taken = 1'b0;
                endcase
            end
            S_HALTED: begin
                w_halted = 1'b1;
            end
            S_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign imem.req      = w_req;
    assign imem.addr     = w_addr;
    assign o_pc_advance  = w_advance;
    assign o_instr_valid = w_valid;
    assign o_halted      = w_halted;
    assign o_fault       = w_fault;
    assign o_instr       = r_instr;
    assign o_pc_control  = w_taken ? 8'hFF : 8'h00;
    assign o_jump_offset = w_taken ? {{3{r_instr[4]}}, r_instr[4:0]} : 8'h00;

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Bench for fetch_branch_unit: an integrated PC register driven by the DUT's
// strobes, directed scenarios, then a randomized instruction stream checked
// against an instruction-level model of pc and decode.
module tb_fetch_branch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pc_dut;
    logic       zero_flag;
    logic [7:0] pc_control;
    logic [7:0] jump_offset;
    logic       pc_advance;
    logic [7:0] instr;
    logic       instr_valid;
    logic       halted;
    logic       fault;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] pc_model;
    logic [7:0] last_word;

    fetch_branch_unit_if imem_bus ();

    fetch_branch_unit #(.TIMEOUT(15)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pc          (pc_dut),
        .i_zero_flag   (zero_flag),
        .imem          (imem_bus.master),
        .o_pc_control  (pc_control),
        .o_jump_offset (jump_offset),
        .o_pc_advance  (pc_advance),
        .o_instr       (instr),
        .o_instr_valid (instr_valid),
        .o_halted      (halted),
        .o_fault       (fault)
    );

    always #5 clk = ~clk;

    // Program counter as it sits in the integrated system.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_dut <= 8'h00;
        else if (pc_advance) pc_dut <= pc_dut + 8'd1 + (pc_control & jump_offset);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge of the first FETCH cycle after reset.
    task automatic do_reset();
        rst_n         = 1'b0;
        imem_bus.ack  = 1'b1;
        imem_bus.data = 8'($urandom);
        zero_flag     = 1'b0;
        pc_model      = 8'h00;
        last_word     = 8'h00;
        @(negedge clk);
        check("rst_req",   imem_bus.req, 0);
        check("rst_adv",   pc_advance,   0);
        check("rst_valid", instr_valid,  0);
        check("rst_ctrl",  pc_control,   0);
        check("rst_off",   jump_offset,  0);
        check("rst_halt",  halted,       0);
        check("rst_fault", fault,        0);
        check("rst_instr", instr,        0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        imem_bus.ack = 1'b0;
        @(negedge clk);
        check("idle_req", imem_bus.req, 0);
        @(negedge clk);
        check("first_req",  imem_bus.req,  1);
        check("first_addr", imem_bus.addr, 32'(pc_model));
    endtask

    // Starts and ends at the falling edge of a first FETCH cycle (unless HALT).
    task automatic exec_instr(input logic [7:0] word, input logic zf, input int delay);
        int   s;
        int   next_pc;
        logic taken;
        logic is_halt;
        s = int'(word[4:0]);
        if (word[4]) s = s - 32;
        is_halt = (word[7:5] == 3'd5);
        taken   = (word[7:5] == 3'd7) || (word[7:5] == 3'd6 && zf);
        next_pc = (int'(pc_model) + 1 + (taken ? s : 0)) & 255;
        for (int k = 0; k < delay; k++) begin
            check("wait_req",  imem_bus.req,  1);
            check("wait_addr", imem_bus.addr, 32'(pc_model));
            check("wait_fault", fault, 0);
            imem_bus.ack  = 1'b0;
            imem_bus.data = 8'($urandom);
            @(negedge clk);
        end
        check("fetch_req",  imem_bus.req,  1);
        check("fetch_addr", imem_bus.addr, 32'(pc_model));
        check("pc_sync",    pc_dut,        32'(pc_model));
        imem_bus.ack  = 1'b1;
        imem_bus.data = word;
        zero_flag     = zf;
        @(negedge clk);
        imem_bus.ack  = 1'($urandom_range(0, 1));
        imem_bus.data = 8'($urandom);
        #1;
        check("ex_valid", instr_valid,  1);
        check("ex_instr", instr,        32'(word));
        check("ex_req",   imem_bus.req, 0);
        check("ex_adv",   pc_advance,   is_halt ? 0 : 1);
        check("ex_ctrl",  pc_control,   taken ? 32'hFF : 0);
        check("ex_off",   jump_offset,  taken ? (s & 255) : 0);
        check("ex_fault", fault,        0);
        last_word = word;
        if (is_halt) begin
            @(negedge clk);
            check("halt_set", halted, 1);
            for (int k = 0; k < 6; k++) begin
                imem_bus.ack  = 1'($urandom_range(0, 1));
                imem_bus.data = 8'($urandom);
                @(negedge clk);
                check("halt_sticky", halted,       1);
                check("halt_valid",  instr_valid,  0);
                check("halt_adv",    pc_advance,   0);
                check("halt_req",    imem_bus.req, 0);
                check("halt_instr",  instr,        32'(word));
                check("halt_pc",     pc_dut,       32'(pc_model));
            end
            imem_bus.ack = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            pc_model     = 8'(next_pc);
            imem_bus.ack = 1'b0;
            @(negedge clk);
            check("refetch_req", imem_bus.req, 1);
            check("pc_after",    pc_dut,       32'(pc_model));
        end
    endtask

    task automatic timeout_fault();
        for (int k = 0; k < 16; k++) begin
            check("to_req",   imem_bus.req, 1);
            check("to_fault", fault,        0);
            imem_bus.ack = 1'b0;
            @(negedge clk);
        end
        check("fault_set", fault,        1);
        check("fault_req", imem_bus.req, 0);
        for (int k = 0; k < 5; k++) begin
            imem_bus.ack  = 1'($urandom_range(0, 1));
            imem_bus.data = 8'($urandom);
            @(negedge clk);
            check("fault_sticky", fault,        1);
            check("fault_valid",  instr_valid,  0);
            check("fault_req2",   imem_bus.req, 0);
            check("fault_adv",    pc_advance,   0);
            check("fault_instr",  instr,        32'(last_word));
        end
        imem_bus.ack = 1'b0;
    endtask

    initial begin
        int   r;
        int   d;
        logic [7:0] w;
        imem_bus.ack  = 1'b0;
        imem_bus.data = 8'h00;
        zero_flag     = 1'b0;
        rst_n         = 1'b0;
        #2;
        do_reset();

        // asynchronous abort in FETCH
        rst_n = 1'b0;
        #1;
        check("async_req", imem_bus.req, 0);
        do_reset();

        exec_instr(8'h01, 1'b0, 0);
        check("nb_pc", pc_dut, 1);

        do_reset();
        exec_instr(8'hE3, 1'b0, 0);
        check("jmp_fwd_pc", pc_dut, 4);
        exec_instr(8'hFE, 1'b0, 1);
        check("jmp_back_pc", pc_dut, 3);
        exec_instr(8'hDE, 1'b0, 0);
        check("beqz_nt_pc", pc_dut, 4);
        exec_instr(8'hDE, 1'b1, 2);
        check("beqz_t_pc", pc_dut, 3);

        // wrap-around both directions
        do_reset();
        exec_instr(8'hFE, 1'b0, 0);
        check("wrap_ff", pc_dut, 8'hFF);
        exec_instr(8'h01, 1'b0, 0);
        check("wrap_00", pc_dut, 0);
        exec_instr(8'h40, 1'b1, 0);
        exec_instr(8'hF0, 1'b0, 0);
        check("wrap_back", pc_dut, 8'hF2);

        // ack in the last tolerated cycle, and one before it
        exec_instr(8'h22, 1'b0, 15);
        exec_instr(8'hC1, 1'b1, 14);

        timeout_fault();
        do_reset();
        check("fault_cleared", fault, 0);

        // asynchronous abort in EXECUTE
        imem_bus.ack  = 1'b1;
        imem_bus.data = 8'hE3;
        @(negedge clk);
        imem_bus.ack = 1'b0;
        check("mid_ex_valid", instr_valid, 1);
        rst_n = 1'b0;
        #1;
        check("abort_valid", instr_valid, 0);
        check("abort_instr", instr,       0);
        check("abort_ctrl",  pc_control,  0);
        do_reset();

        for (int i = 0; i < 80; i++) begin
            w = 8'($urandom);
            if (w[7:5] == 3'd5) w[7:5] = 3'd6;
            r = $urandom_range(0, 9);
            if (r < 6) d = 0;
            else if (r < 9) d = $urandom_range(1, 5);
            else d = 15;
            exec_instr(w, 1'($urandom_range(0, 1)), d);
        end

        exec_instr(8'hA0, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_branch_unit.md
Name: fetch_branch_unit

Overview:
Instruction-side companion to the 8-bit program counter. It reads the instruction at the current pc from instruction memory over a req/ack handshake, then decodes it. It drives the PC's pc_control and jump_offset inputs plus a one-cycle pc_advance strobe. In integration, pc_advance qualifies the PC update, so the PC moves exactly once per executed instruction.

Parameters:
TIMEOUT, 15, number of consecutive un-acked FETCH cycles tolerated before FAULT (legal 1..255; wait counter is 8 bits)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
pc  input  8  current program counter value
zero_flag  input  1  ALU zero flag, sampled in EXECUTE
imem_addr  output  8  instruction memory address
imem_req  output  1  fetch request
imem_ack  input  1  memory response; imem_data valid in the same cycle
imem_data  input  8  instruction word: opcode [7:5], operand [4:0]
pc_control  output  8  8'hFF when branch taken, else 8'h00
jump_offset  output  8  sign-extended operand when taken, else 8'h00
pc_advance  output  1  one-cycle strobe: PC takes pc+1+(pc_control&jump_offset) at this edge
instr  output  8  last captured instruction word
instr_valid  output  1  high in EXECUTE cycle
halted  output  1  sticky, set by HALT
fault  output  1  sticky, set on fetch timeout

Behaviour:
- Reset (async assert, synchronous-to-clk release):
  - state=IDLE; instr=0; wait counter=0.
  - All outputs 0: req, advance, valid, pc_control, jump_offset, halted, fault.
  - rst_n low at any time, including mid-FETCH or mid-EXECUTE, aborts immediately to IDLE; any pending ack is discarded.
- States: IDLE, FETCH, EXECUTE, HALTED, FAULT. All outputs are decoded from registered state and instr only; none depend combinationally on imem_ack.
- IDLE: unconditional -> FETCH on the next edge. First req is therefore the second cycle after rst_n release.
- FETCH:
  - imem_req=1, imem_addr=pc. pc is stable because pc_advance=0.
  - Req is held until ack.
  - On imem_ack=1: instr<=imem_data, counter<=0, -> EXECUTE.
  - Else counter+1. If counter==TIMEOUT with no ack -> FAULT, so ack is accepted in any of the first TIMEOUT+1 FETCH cycles.
- EXECUTE (exactly 1 cycle):
  - imem_req=0, instr_valid=1, pc_advance=1.
  - Decode on instr[7:5]:
    - 3'b111 JMP: taken.
    - 3'b110 BEQZ: taken iff zero_flag=1.
    - 3'b101 HALT: not taken, pc_advance=0, -> HALTED.
    - All other opcodes: not taken (no PC effect).
  - Taken: pc_control=8'hFF, jump_offset={{3{instr[4]}},instr[4:0]}.
  - Not taken: both 8'h00.
  - Next state FETCH (except HALT).
- Throughput and latency: minimum 2 cycles per instruction (ack in first FETCH cycle). The PC update lands on the edge ending EXECUTE, i.e. one cycle after the ack edge.
- Branch arithmetic is mod 256: new pc = pc+1+offset. Wrap-around in both directions is legal (pc=8'hFF non-branch -> 8'h00; pc=8'h01, offset 8'hF0 -> 8'hF2).
- HALTED: halted=1; req, advance and valid all 0. Remains until reset; imem_ack ignored.
- FAULT: fault=1; req, advance and valid all 0. Remains until reset.
- imem_ack outside FETCH is ignored and never captured.
- Ack in the same cycle counter reaches TIMEOUT: ack wins -> EXECUTE, no fault.

Test Plan:
- Reset: hold rst_n=0 with imem_ack=1 -> all outputs 0. Release -> imem_req=1 and imem_addr=pc on second edge. Assert rst_n=0 mid-FETCH -> imem_req drops immediately (async).
- Non-branch: pc=0, ack same cycle with imem_data=8'h01 -> next cycle instr_valid=1, instr=8'h01, pc_advance=1, pc_control=8'h00, jump_offset=8'h00. PC becomes 1; imem_req=1 again the following cycle.
- JMP forward/backward: 8'hE3 at pc=0 -> pc_control=8'hFF, jump_offset=8'h03, pc becomes 4. Then 8'hFE at pc=4 -> jump_offset=8'hFE, pc becomes 3.
- BEQZ: 8'hDE with zero_flag=0 -> pc_control=0, pc 3->4. Same word with zero_flag=1 -> pc_control=8'hFF, jump_offset=8'hFE, pc 4->3.
- HALT and stray ack: 8'hA0 -> pc_advance=0 in EXECUTE, halted=1 next cycle. Later ack pulses do not set instr_valid or change instr; PC frozen.
- Timeout (TIMEOUT=15): withhold ack 16 FETCH cycles -> fault=1, imem_req=0. Separately, ack on the 16th cycle -> no fault, normal EXECUTE. Reset clears fault.
